// File: rtl/adc_decim_fifo_if.sv
// Read-side bus between the decimating FIFO and the PMP output stage.
// Handshake: out_valid=1 means adc_data_out holds a stored FIFO head. Each rising edge
// of pmp_dreq, after a 2-FF synchronizer, consumes that head (one pop per rising edge).
// A request that arrives while out_valid=0 is ignored, and adc_data_out keeps its value.
interface adc_decim_fifo_if #(
   parameter int DATA_W = 8
);
   logic              pmp_dreq;
   logic [DATA_W-1:0] adc_data_out;
   logic              out_valid;

   modport master (input pmp_dreq, output adc_data_out, output out_valid);
   modport slave  (output pmp_dreq, input adc_data_out, input out_valid);
endinterface

// File: rtl/adc_decim_fifo.sv
// ADC decimator (pick / max / min over a runtime window) that feeds a small FIFO.
// The FIFO is drained one entry per synchronized rising edge of pmp_dreq.
module adc_decim_fifo #(
   parameter int DATA_W  = 8,
   parameter int DECIM_W = 16,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATA_W-1:0]  adc_data,
   input  logic               en,
   input  logic [DECIM_W-1:0] decim_ratio,
   input  logic [1:0]         decim_mode,
   input  logic               ovf_clr,
   output logic               decim_clk,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               ovf,
   adc_decim_fifo_if.master   rd_bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [DECIM_W-1:0] RATIO_ONE = DECIM_W'(1);
   localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

   // window state
   logic [DECIM_W-1:0] cnt, ratio_l, ratio_in, ratio_cur;
   logic [DATA_W-1:0]  acc, ext, win_result;
   logic               win_last, push_req, is_max, is_min, is_pick;

   // read-side synchronizer
   logic s1, s2, s3, pop_req;

   // fifo state
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, count, cnt_nxt;
   logic               full, empty, pop_eff, push_eff, drop;
   logic [DATA_W-1:0]  head_nxt;

   // A zero ratio counts as one. The live input ratio applies only at window start (cnt==0).
   assign ratio_in  = (decim_ratio == '0) ? RATIO_ONE : decim_ratio;
   assign ratio_cur = (cnt == '0) ? ratio_in : ratio_l;
   assign win_last  = (cnt == ratio_cur - RATIO_ONE);
   assign push_req  = en & win_last;
   assign is_max    = (decim_mode == 2'b01);
   assign is_min    = (decim_mode == 2'b10);
   assign is_pick   = ~is_max & ~is_min;

   // Extremum of the running accumulator and the current sample.
   always_comb begin
      ext = acc;
      if (is_max && (adc_data > acc)) ext = adc_data;
      if (is_min && (adc_data < acc)) ext = adc_data;
      win_result = (is_pick || (cnt == '0)) ? adc_data : ext;
   end

   // Window counter, latched ratio and accumulator. en=0 parks the window at its start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         ratio_l <= '0;
         acc     <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else begin
         if (cnt == '0) ratio_l <= ratio_in;
         cnt <= win_last ? '0 : cnt + RATIO_ONE;
         acc <= (cnt == '0) ? adc_data : ext;
      end
   end

   // Registered window-completion strobe, aligned with the FIFO update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) decim_clk <= 1'b0;
      else        decim_clk <= push_req;
   end

   // 2-FF synchronizer for the asynchronous dreq, plus a delay stage for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= rd_bus.pmp_dreq;
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign pop_req = s2 & ~s3;

   // Pop is resolved first, so a push into a full FIFO that is popped that cycle still fits.
   assign count      = wr_ptr - rd_ptr;
   assign fifo_count = count;
   assign full       = (count == DEPTH_C);
   assign empty      = (count == '0);
   assign pop_eff    = pop_req & ~empty;
   assign push_eff   = push_req & (~full | pop_eff);
   assign drop       = push_req & full & ~pop_eff;
   assign rd_nxt     = rd_ptr + {{FIFO_AW{1'b0}}, pop_eff};
   assign wr_nxt     = wr_ptr + {{FIFO_AW{1'b0}}, push_eff};
   assign cnt_nxt    = wr_nxt - rd_nxt;
   // If the next head is the slot being written this cycle, bypass the RAM.
   assign head_nxt   = (rd_nxt == wr_ptr) ? win_result : mem[rd_nxt[FIFO_AW-1:0]];

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr[FIFO_AW-1:0]] <= win_result;
   end

   // Pointers, sticky overflow flag and the registered head/valid outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         ovf                 <= 1'b0;
         rd_bus.out_valid    <= 1'b0;
         rd_bus.adc_data_out <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         rd_bus.out_valid <= (cnt_nxt != '0);
         if (cnt_nxt != '0) rd_bus.adc_data_out <= head_nxt;
      end
   end
endmodule

// File: tb/tb_adc_decim_fifo.sv
// Bench for adc_decim_fifo: directed scenarios plus a randomized run, all checked
// against a sample-list / queue reference model.
module tb_adc_decim_fifo;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  adc_data;
   logic        en;
   logic [15:0] decim_ratio;
   logic [1:0]  decim_mode;
   logic        ovf_clr;
   logic        decim_clk;
   logic [4:0]  fifo_count;
   logic        ovf;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [7:0] exp_q[$];
   logic [7:0] win_q[$];
   int         m_ratio;
   logic [7:0] m_head;
   logic       m_ovf, m_dclk;
   logic       d1, d2, d3;

   adc_decim_fifo_if #(.DATA_W(8)) bus ();

   adc_decim_fifo #(.DATA_W(8), .DECIM_W(16), .FIFO_AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .en(en),
      .decim_ratio(decim_ratio), .decim_mode(decim_mode), .ovf_clr(ovf_clr),
      .decim_clk(decim_clk), .fifo_count(fifo_count), .ovf(ovf), .rd_bus(bus)
   );

   // clock
   always #5 clk = ~clk;

   task automatic model_reset();
      exp_q.delete();
      win_q.delete();
      m_ratio = 1;
      m_head  = 8'd0;
      m_ovf   = 1'b0;
      m_dclk  = 1'b0;
      d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
   endtask

   // One clock edge of the reference behaviour, from the inputs present at the edge.
   task automatic model_step();
      logic       pop, push, drop;
      logic [7:0] res;
      pop = d2 & ~d3;
      d3 = d2; d2 = d1; d1 = bus.pmp_dreq;
      push = 1'b0;
      res  = 8'd0;
      if (en) begin
         if (win_q.size() == 0) m_ratio = (decim_ratio == 16'd0) ? 1 : int'(decim_ratio);
         win_q.push_back(adc_data);
         if (win_q.size() == m_ratio) begin
            res = adc_data;
            if (decim_mode == 2'b01) foreach (win_q[i]) if (win_q[i] > res) res = win_q[i];
            if (decim_mode == 2'b10) foreach (win_q[i]) if (win_q[i] < res) res = win_q[i];
            push = 1'b1;
            win_q.delete();
         end
      end else begin
         win_q.delete();
      end
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      drop = 1'b0;
      if (push) begin
         if (exp_q.size() < 16) exp_q.push_back(res);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_dclk = push;
      if (exp_q.size() > 0) m_head = exp_q[0];
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0; adc_data = 8'd0; decim_ratio = 16'd1; decim_mode = 2'b00;
      ovf_clr = 1'b0; bus.pmp_dreq = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pop_once();
      bus.pmp_dreq = 1'b1;
      tick();
      tick();
      bus.pmp_dreq = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1; adc_data = 8'h5a; decim_ratio = 16'd1; decim_mode = 2'b00;
      ovf_clr = 1'b0; bus.pmp_dreq = 1'b0;
      model_reset();
      #2;
      tick();
      tick();
      tests++;
      if ({bus.adc_data_out, bus.out_valid, decim_clk, fifo_count, ovf} !== 16'd0) begin
         $display("FAIL reset_outputs: got data=%0d valid=%0b dclk=%0b count=%0d ovf=%0b, want all 0",
                  bus.adc_data_out, bus.out_valid, decim_clk, fifo_count, ovf);
         fails++;
      end
   endtask

   task automatic test_pick_ramp();
      do_reset();
      decim_ratio = 16'd4; decim_mode = 2'b00; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         adc_data = 8'(i);
         tick();
         tests++;
         if (decim_clk !== ((i % 4) == 3)) begin
            $display("FAIL pick_strobe[%0d]: got %0b want %0b", i, decim_clk, (i % 4) == 3);
            fails++;
         end
      end
      en = 1'b0;
      tests++;
      if (fifo_count !== 5'd4 || bus.adc_data_out !== 8'd3) begin
         $display("FAIL pick_fifo: got count=%0d head=%0d want count=4 head=3",
                  fifo_count, bus.adc_data_out);
         fails++;
      end
      for (int i = 0; i < 3; i++) begin
         pop_once();
         tests++;
         if (bus.adc_data_out !== 8'(7 + 4 * i)) begin
            $display("FAIL pick_order[%0d]: got %0d want %0d", i, bus.adc_data_out, 7 + 4 * i);
            fails++;
         end
      end
   endtask

   task automatic test_max_min();
      logic [7:0] data [6];
      logic [7:0] want [4];
      data = '{8'd5, 8'd9, 8'd2, 8'd1, 8'd1, 8'd8};
      want = '{8'd9, 8'd8, 8'd2, 8'd1};
      for (int m = 0; m < 2; m++) begin
         do_reset();
         decim_ratio = 16'd3; decim_mode = (m == 0) ? 2'b01 : 2'b10; en = 1'b1;
         for (int i = 0; i < 6; i++) begin
            adc_data = data[i];
            tick();
         end
         en = 1'b0;
         tests++;
         if (fifo_count !== 5'd2 || bus.adc_data_out !== want[2 * m]) begin
            $display("FAIL maxmin_first[%0d]: got count=%0d head=%0d want count=2 head=%0d",
                     m, fifo_count, bus.adc_data_out, want[2 * m]);
            fails++;
         end
         pop_once();
         tests++;
         if (bus.adc_data_out !== want[2 * m + 1]) begin
            $display("FAIL maxmin_second[%0d]: got %0d want %0d", m, bus.adc_data_out, want[2 * m + 1]);
            fails++;
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      decim_ratio = 16'd1; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         adc_data = 8'($urandom_range(0, 255));
         tick();
      end
      tests++;
      if (fifo_count !== 5'd16 || ovf !== 1'b0) begin
         $display("FAIL ovf_full: got count=%0d ovf=%0b want 16/0", fifo_count, ovf);
         fails++;
      end
      tick();
      tests++;
      if (fifo_count !== 5'd16 || ovf !== 1'b1) begin
         $display("FAIL ovf_drop: got count=%0d ovf=%0b want 16/1", fifo_count, ovf);
         fails++;
      end
      ovf_clr = 1'b1;
      tick();
      tests++;
      if (ovf !== 1'b1) begin
         $display("FAIL ovf_clr_with_drop: got ovf=%0b want 1", ovf);
         fails++;
      end
      en = 1'b0;
      tick();
      ovf_clr = 1'b0;
      tests++;
      if (fifo_count !== 5'd16 || ovf !== 1'b0) begin
         $display("FAIL ovf_clear: got count=%0d ovf=%0b want 16/0", fifo_count, ovf);
         fails++;
      end
   endtask

   task automatic test_read_pops();
      logic [7:0] vals [3];
      vals = '{8'd10, 8'd20, 8'd30};
      do_reset();
      decim_ratio = 16'd1; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adc_data = vals[i];
         tick();
      end
      en = 1'b0;
      // latency check on the first request
      bus.pmp_dreq = 1'b1;
      tick();
      tick();
      tests++;
      if (bus.adc_data_out !== 8'd10 || fifo_count !== 5'd3) begin
         $display("FAIL pop_latency_early: got head=%0d count=%0d want 10/3", bus.adc_data_out, fifo_count);
         fails++;
      end
      tick();
      tests++;
      if (bus.adc_data_out !== 8'd20 || fifo_count !== 5'd2) begin
         $display("FAIL pop_latency_edge: got head=%0d count=%0d want 20/2", bus.adc_data_out, fifo_count);
         fails++;
      end
      // held-high request must not pop again
      tick();
      tick();
      tests++;
      if (fifo_count !== 5'd2) begin
         $display("FAIL pop_held_high: got count=%0d want 2", fifo_count);
         fails++;
      end
      bus.pmp_dreq = 1'b0;
      tick();
      tick();
      pop_once();
      tests++;
      if (bus.adc_data_out !== 8'd30 || bus.out_valid !== 1'b1) begin
         $display("FAIL pop_second: got head=%0d valid=%0b want 30/1", bus.adc_data_out, bus.out_valid);
         fails++;
      end
      for (int i = 0; i < 2; i++) begin
         pop_once();
         tests++;
         if (bus.adc_data_out !== 8'd30 || bus.out_valid !== 1'b0 || fifo_count !== 5'd0) begin
            $display("FAIL pop_empty[%0d]: got head=%0d valid=%0b count=%0d want 30/0/0",
                     i, bus.adc_data_out, bus.out_valid, fifo_count);
            fails++;
         end
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      decim_ratio = 16'd1; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         adc_data = 8'(100 + i);
         tick();
      end
      en = 1'b0;
      bus.pmp_dreq = 1'b1;
      tick();
      tick();
      en = 1'b1; adc_data = 8'd99;
      tick();
      en = 1'b0; bus.pmp_dreq = 1'b0;
      tick();
      tick();
      tests++;
      if (fifo_count !== 5'd16 || ovf !== 1'b0 || bus.adc_data_out !== 8'd101) begin
         $display("FAIL full_pushpop: got count=%0d ovf=%0b head=%0d want 16/0/101",
                  fifo_count, ovf, bus.adc_data_out);
         fails++;
      end
      for (int i = 0; i < 15; i++) begin
         pop_once();
         tests++;
         if (bus.adc_data_out !== ((i == 14) ? 8'd99 : 8'(102 + i))) begin
            $display("FAIL full_order[%0d]: got %0d want %0d", i, bus.adc_data_out,
                     (i == 14) ? 99 : 102 + i);
            fails++;
         end
      end
   endtask

   task automatic test_ratio_changes();
      logic exp_dclk [6];
      exp_dclk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      decim_ratio = 16'd0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adc_data = 8'($urandom_range(0, 255));
         tick();
         tests++;
         if (decim_clk !== 1'b1 || bus.adc_data_out !== m_head || fifo_count !== 5'(i + 1)) begin
            $display("FAIL ratio0[%0d]: got dclk=%0b head=%0d count=%0d want 1/%0d/%0d",
                     i, decim_clk, bus.adc_data_out, fifo_count, m_head, i + 1);
            fails++;
         end
      end
      do_reset();
      decim_ratio = 16'd4; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         adc_data = 8'(i);
         tick();
         if (i == 0) decim_ratio = 16'd2;
         tests++;
         if (decim_clk !== exp_dclk[i]) begin
            $display("FAIL ratio_change[%0d]: got dclk=%0b want %0b", i, decim_clk, exp_dclk[i]);
            fails++;
         end
      end
      // reset in the middle of a window with five stored entries
      do_reset();
      decim_ratio = 16'd1; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         adc_data = 8'(40 + i);
         tick();
      end
      decim_ratio = 16'd4;
      tick();
      tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      tests++;
      if ({bus.adc_data_out, bus.out_valid, decim_clk, fifo_count, ovf} !== 16'd0) begin
         $display("FAIL async_reset: got data=%0d valid=%0b dclk=%0b count=%0d ovf=%0b want all 0",
                  bus.adc_data_out, bus.out_valid, decim_clk, fifo_count, ovf);
         fails++;
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         adc_data = 8'(60 + i);
         tick();
         tests++;
         if (decim_clk !== (i == 3) || fifo_count !== ((i == 3) ? 5'd1 : 5'd0)) begin
            $display("FAIL post_reset[%0d]: got dclk=%0b count=%0d want %0b/%0d",
                     i, decim_clk, fifo_count, i == 3, (i == 3) ? 1 : 0);
            fails++;
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         adc_data = 8'($urandom_range(0, 255));
         en       = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) decim_ratio = 16'($urandom_range(0, 5));
         if (win_q.size() == 0 && $urandom_range(0, 5) == 0) decim_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) bus.pmp_dreq = ~bus.pmp_dreq;
         ovf_clr = ($urandom_range(0, 15) == 0);
         tick();
         tests++;
         if (fifo_count !== 5'(exp_q.size()) || bus.out_valid !== (exp_q.size() > 0)) begin
            $display("FAIL rand_count[%0d]: got count=%0d valid=%0b want %0d/%0b",
                     c, fifo_count, bus.out_valid, exp_q.size(), exp_q.size() > 0);
            fails++;
         end
         tests++;
         if (bus.adc_data_out !== m_head) begin
            $display("FAIL rand_head[%0d]: got %0d want %0d", c, bus.adc_data_out, m_head);
            fails++;
         end
         tests++;
         if (ovf !== m_ovf || decim_clk !== m_dclk) begin
            $display("FAIL rand_flags[%0d]: got ovf=%0b dclk=%0b want %0b/%0b",
                     c, ovf, decim_clk, m_ovf, m_dclk);
            fails++;
         end
      end
      ovf_clr = 1'b0;
   endtask

   // sequence and report
   initial begin
      test_reset();
      test_pick_ramp();
      test_max_min();
      test_overflow();
      test_read_pops();
      test_full_push_pop();
      test_ratio_changes();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // safety net against a stalled run
   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end
endmodule
